// File: rtl/mux_router.sv
// mux_router: steers one upstream valid/ready stream to three one-entry
// output registers by a 2-bit destination select, or discards the item
// (destination 00) and counts the discard in a saturating 4-bit counter.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. in_ready is a combinational function of in_dest, the selected
// slot's occupancy and that slot's sink ready; it never looks at in_valid.
// opN_valid never waits on opN_ready, and opN_data holds stable while
// opN_valid=1 and opN_ready=0.
module mux_router #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_dest,
   output logic             in_ready,
   output logic [WIDTH-1:0] op1_data,
   output logic             op1_valid,
   input  logic             op1_ready,
   output logic [WIDTH-1:0] op2_data,
   output logic             op2_valid,
   input  logic             op2_ready,
   output logic [WIDTH-1:0] op3_data,
   output logic             op3_valid,
   input  logic             op3_ready,
   output logic [3:0]       drop_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   // Index 0..2 corresponds to destinations 01..11 (op1..op3).
   logic [2:0]         sink_ready;
   logic [2:0]         slot_valid;
   logic [2:0]         slot_load;
   logic [3*WIDTH-1:0] slot_data_flat;
   logic               xfer_in;
   logic               drop;

   assign sink_ready = {op3_ready, op2_ready, op1_ready};
   assign xfer_in    = in_valid && in_ready;

   // Ready toward upstream: drops are always taken; a slot can take an item
   // when it is empty or when its current item leaves in this same cycle.
   always_comb begin
      in_ready = 1'b1;
      if (in_dest != 2'b00) begin
         in_ready = !slot_valid[in_dest - 2'd1] || sink_ready[in_dest - 2'd1];
      end
   end

   // Decode an accepted item into either a slot load or a discard.
   always_comb begin
      slot_load = '0;
      drop      = 1'b0;
      if (xfer_in) begin
         if (in_dest == 2'b00) begin
            drop = 1'b1;
         end else begin
            slot_load[in_dest - 2'd1] = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_slot
      slot_state_t      state_q;
      slot_state_t      state_d;
      logic [WIDTH-1:0] data_q;

      // Slot occupancy register; reset empties the slot immediately.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state_q <= EMPTY;
         end else begin
            state_q <= state_d;
         end
      end

      // Occupancy next state: a load always leaves the slot FULL (covers the
      // simultaneous in/out case without a bubble); an unloaded delivery empties it.
      always_comb begin
         state_d = state_q;
         case (state_q)
            EMPTY: if (slot_load[i]) state_d = FULL;
            FULL:  if (sink_ready[i] && !slot_load[i]) state_d = EMPTY;
         endcase
      end

      // Payload register; only written on a load, so it holds while stalled.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            data_q <= '0;
         end else if (slot_load[i]) begin
            data_q <= in_data;
         end
      end

      // The valid output is the slot state itself, so it doubles as the
      // observable FSM state for each slot.
      assign slot_valid[i]                      = (state_q == FULL);
      assign slot_data_flat[i*WIDTH +: WIDTH]   = data_q;
   end

   // Saturating count of discarded items.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_count <= 4'd0;
      end else if (drop && (drop_count != 4'hF)) begin
         drop_count <= drop_count + 4'd1;
      end
   end

   assign op1_valid = slot_valid[0];
   assign op2_valid = slot_valid[1];
   assign op3_valid = slot_valid[2];
   assign op1_data  = slot_data_flat[WIDTH-1:0];
   assign op2_data  = slot_data_flat[2*WIDTH-1:WIDTH];
   assign op3_data  = slot_data_flat[3*WIDTH-1:2*WIDTH];

endmodule

// File: doc/mux_router.md
MUX_ROUTER -- requirements
Module: mux_router

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, setting the data width of the input and all outputs.
REQ-002 Port clock, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: the reset SHALL be asynchronous and active-high.
REQ-004 Port in_valid, input, 1: the upstream item is present.
REQ-005 Port in_data, input, WIDTH: the upstream item payload.
REQ-006 Port in_dest, input, 2: the destination select (01->op1, 10->op2, 11->op3, 00->drop).
REQ-007 Port in_ready, output, 1: the module accepts the item this cycle.
REQ-008 For each N in 1..3, port opN_data SHALL be an output of WIDTH bits carrying the registered payload for destination N.
REQ-009 For each N in 1..3, port opN_valid SHALL be an output of 1 bit indicating that opN_data holds an undelivered item.
REQ-010 For each N in 1..3, port opN_ready SHALL be an input of 1 bit indicating that the sink for destination N takes the item this cycle.
REQ-011 Port drop_count, output, 4: the saturating count of items accepted with in_dest=00.

Function
REQ-012 A transfer-in SHALL occur in a cycle where in_valid=1 and in_ready=1, sampled at the rising clock edge.
REQ-013 A transfer-out on port N SHALL occur in a cycle where opN_valid=1 and opN_ready=1.
REQ-014 Each output N SHALL be a one-entry register with two states: EMPTY (opN_valid=0) and FULL (opN_valid=1).
REQ-015 in_ready SHALL be combinational: 1 when in_dest=00; otherwise (!opN_valid || opN_ready) for the selected N.
REQ-016 in_ready SHALL NOT depend on in_valid.
REQ-017 On a transfer-in to N, opN_data SHALL load in_data and opN_valid SHALL be 1 from the next cycle (latency 1 cycle).
REQ-018 EMPTY->FULL: transfer-in to N occurs with no transfer-out on N.
REQ-019 FULL->EMPTY: transfer-out on N occurs with no transfer-in to N.
REQ-020 FULL->FULL with new data: transfer-out and transfer-in on N occur in the same cycle; opN_valid SHALL stay 1 with no bubble.
REQ-021 While opN_valid=1 and opN_ready=0, opN_data SHALL hold stable.
REQ-022 Outputs not selected by the current transfer-in SHALL be unaffected by it.
REQ-023 Transfer-outs on different outputs SHALL proceed independently in the same cycle.
REQ-024 opN_ready while opN_valid=0 SHALL have no effect.
REQ-025 A transfer-in with in_dest=00 SHALL discard the item and increment drop_count by 1.
REQ-026 drop_count SHALL saturate at 15 and not wrap.
REQ-027 When in_valid=0, no output register and no counter SHALL change except through transfer-outs.
REQ-028 The output registers SHALL store data only; they SHALL NOT reorder items, and one item SHALL be delivered per transfer-in to a valid destination.

Reset
REQ-029 While reset=1, all opN_valid SHALL be 0, all opN_data SHALL be 0, and drop_count SHALL be 0, independent of clock.
REQ-030 Reset asserted mid-operation SHALL discard any held item immediately.
REQ-031 A transfer-in coincident with reset assertion SHALL be lost.
REQ-032 After reset deasserts, the first rising edge SHALL accept a transfer-in normally.
REQ-033 in_ready during reset SHALL follow REQ-015 with all outputs EMPTY.

Verification
REQ-034 The bench SHALL cover: reset; in_valid=1, in_dest=01, in_data=4'hA, op1_ready=0 -> next cycle op1_valid=1, op1_data=4'hA, op2_valid=op3_valid=0, in_ready=0 while in_dest=01.
REQ-035 The bench SHALL cover: op1 FULL with 4'hA, op1_ready=1, in_valid=1, in_dest=01, in_data=4'h5 -> in_ready=1, next cycle op1_valid=1, op1_data=4'h5, with 4'hA counted delivered exactly once.
REQ-036 The bench SHALL cover: op2 FULL with op2_ready=0 and in_dest=11, in_data=4'h3 -> in_ready=1, op3_data=4'h3 next cycle, op2_data unchanged.
REQ-037 The bench SHALL cover: 17 consecutive transfer-ins with in_dest=00 -> drop_count reads 1..15, then holds at 15; no opN_valid rises.
REQ-038 The bench SHALL cover: op1..op3 all FULL, reset pulsed asynchronously between clock edges -> all opN_valid, opN_data and drop_count are 0 before the next edge.
REQ-039 The bench SHALL cover: a random stream with random opN_ready, checked against a scoreboard of per-destination FIFO order -> no loss, duplication or data change while stalled.
